// File: rtl/sram_ctrl64.sv
// Sequences a 64-bit external SRAM (17-bit word address) for the MEM stage, one 32-bit word per request.
// Latency: request in IDLE cycle 0, ACCESS cycles 1..WAIT_CYCLES, DONE (READY=1) in cycle WAIT_CYCLES+1.
// Backpressure: READY=0 freezes the pipeline while a request is in flight; a request held past DONE starts a new access.
//
// Optional feature macro: SRAM_LINE_CACHE_EN
//   When defined, a one-entry 64-bit line buffer serves IDLE read hits in the same cycle
//   and is written through by writes to the buffered line.
//
// Ports:
//   CLK, RST_N          clock (rising edge) and asynchronous active-low reset
//   MEM_R_EN, MEM_W_EN  read / write request, held until READY (write wins if both)
//   ADDR, WR_DATA       CPU byte address and write data, sampled with the request
//   RD_DATA             read word, valid while READY=1 after a read; holds otherwise
//   READY               0 = freeze pipeline
//   SRAM_WE_N           SRAM write enable, active-low
//   SRAM_ADDR           SRAM word address
//   SRAM_DQ             SRAM data bus; driven {32'b0, wdata} only while SRAM_WE_N=0

module sram_ctrl64 #(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ADDR,
    input  logic [31:0] WR_DATA,
    output logic [31:0] RD_DATA,
    output logic        READY,
    output logic        SRAM_WE_N,
    output logic [16:0] SRAM_ADDR,
    inout  wire  [63:0] SRAM_DQ
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [16:0] sram_addr_q;
    logic        we_n_q;
    logic [31:0] wdata_q;
    logic        op_wr_q;
    logic [31:0] rd_data_q;

    // Byte offset from the SRAM window; the word address is bits [18:2],
    // so anything above bit 18 simply wraps modulo 2^17 words.
    logic [31:0] addr_off;
    logic [16:0] word_addr;
    logic        req;
    logic [31:0] rd_half;
    logic        unused_addr_bits;

    assign addr_off         = ADDR - BASE_ADDR;
    assign word_addr        = addr_off[18:2];
    assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};
    assign req              = MEM_R_EN | MEM_W_EN;

    // Even word lives in the low half of the 64-bit line, odd word in the high half.
    assign rd_half = sram_addr_q[0] ? SRAM_DQ[63:32] : SRAM_DQ[31:0];

    // we_n_q resets asynchronously, so the bus is released the moment RST_N falls.
    assign SRAM_DQ   = we_n_q ? 64'bz : {32'b0, wdata_q};
    assign SRAM_WE_N = we_n_q;
    assign SRAM_ADDR = sram_addr_q;

    logic        hit;
    logic [31:0] hit_word;

`ifdef SRAM_LINE_CACHE_EN
    logic [63:0] line_q;
    logic [15:0] tag_q;
    logic        line_vld_q;

    // Only a pure read may hit; a read+write collision is a write.
    assign hit = (state == IDLE) & MEM_R_EN & ~MEM_W_EN & line_vld_q
               & (tag_q == word_addr[16:1]);
    assign hit_word = word_addr[0] ? line_q[63:32] : line_q[31:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            line_q     <= '0;
            tag_q      <= '0;
            line_vld_q <= 1'b0;
        end else begin
            // Read miss fills the whole line at the capture edge.
            if ((state == ACCESS) && (cnt == 4'd0) && !op_wr_q) begin
                line_q     <= SRAM_DQ;
                tag_q      <= sram_addr_q[16:1];
                line_vld_q <= 1'b1;
            end
            // Write-through keeps the buffered line coherent with the SRAM.
            if ((state == DONE) && op_wr_q && line_vld_q
                && (tag_q == sram_addr_q[16:1])) begin
                if (sram_addr_q[0]) begin
                    line_q[63:32] <= wdata_q;
                end else begin
                    line_q[31:0]  <= wdata_q;
                end
            end
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_word = '0;
`endif

    assign READY   = (state == DONE) | ((state == IDLE) & ~req) | hit;
    assign RD_DATA = hit ? hit_word : rd_data_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            cnt         <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            wdata_q     <= '0;
            op_wr_q     <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        // Keep the served word so RD_DATA holds it afterwards.
                        rd_data_q <= hit_word;
                    end else if (req) begin
                        sram_addr_q <= word_addr;
                        wdata_q     <= WR_DATA;
                        op_wr_q     <= MEM_W_EN;
                        we_n_q      <= ~MEM_W_EN;
                        cnt         <= CNT_INIT;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        we_n_q <= 1'b1;
                        if (!op_wr_q) begin
                            rd_data_q <= rd_half;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl64.sv
// Bench for sram_ctrl64: directed cases followed by randomized reads/writes
// against a word-level reference memory and a latency model.
// Includes a behavioural 64-bit SRAM attached to SRAM_DQ.

module tb_sram_ctrl64;

    localparam int          W    = 4;
    localparam logic [31:0] BASE = 32'd1024;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ADDR;
    logic [31:0] WR_DATA;
    logic [31:0] RD_DATA;
    logic        READY;
    logic        SRAM_WE_N;
    logic [16:0] SRAM_ADDR;
    wire  [63:0] SRAM_DQ;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    sram_ctrl64 dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .MEM_R_EN  (MEM_R_EN),
        .MEM_W_EN  (MEM_W_EN),
        .ADDR      (ADDR),
        .WR_DATA   (WR_DATA),
        .RD_DATA   (RD_DATA),
        .READY     (READY),
        .SRAM_WE_N (SRAM_WE_N),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_DQ   (SRAM_DQ)
    );

    // ---------------- external SRAM: 32-bit words, read as 64-bit lines ----------------
    logic [31:0] sram_mem [0:131071];
    logic [63:0] mdl_line;
    logic        mdl_drive = 1'b1;

    assign mdl_line = {sram_mem[{SRAM_ADDR[16:1], 1'b1}], sram_mem[{SRAM_ADDR[16:1], 1'b0}]};
    assign SRAM_DQ  = (SRAM_WE_N && mdl_drive) ? mdl_line : 64'bz;

    initial begin
        for (int i = 0; i < 131072; i++) sram_mem[i] = 32'h0;
        forever begin
            @(posedge CLK);
            if (!SRAM_WE_N) sram_mem[SRAM_ADDR] = SRAM_DQ[31:0];
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd = 32'h0;
    bit          cm_vld  = 1'b0;
    int          cm_tag  = 0;

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off / 4) % 131072);
    endfunction

    function automatic logic [31:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU request, held until READY; checks latency, write strobes,
    // SRAM address and the returned/held read word.
    task automatic access(input bit w, input bit r, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int          low = 0;
        int          wel = 0;
        int          wd;
        bit          is_wr;
        bit          exp_hit;
        logic [16:0] prev_addr;
        logic [31:0] rd;
        logic [16:0] sa;

        wd        = word_of(a);
        is_wr     = w;
        exp_hit   = 1'b0;
`ifdef SRAM_LINE_CACHE_EN
        exp_hit   = r && !w && cm_vld && (cm_tag == wd / 2);
`endif
        @(negedge CLK);
        prev_addr = SRAM_ADDR;
        MEM_W_EN  = w;
        MEM_R_EN  = r;
        ADDR      = a;
        WR_DATA   = d;
        #1;
        while (!READY && low < 40) begin
            low++;
            if (!SRAM_WE_N) wel++;
            @(negedge CLK);
            #1;
        end
        rd = RD_DATA;
        sa = SRAM_ADDR;
        if (low == 0) begin
            // served in IDLE: keep the request through the edge it completes on
            @(posedge CLK);
            #1;
        end
        MEM_W_EN = 1'b0;
        MEM_R_EN = 1'b0;

        if (is_wr) ref_mem[wd] = d;
        else       last_rd     = ref_rd(wd);
`ifdef SRAM_LINE_CACHE_EN
        if (!is_wr && !exp_hit) begin
            cm_vld = 1'b1;
            cm_tag = wd / 2;
        end
`endif
        check({tag, "_latency"}, 64'(low), exp_hit ? 64'd0 : 64'(W + 1));
        check({tag, "_we_cycles"}, 64'(wel), is_wr ? 64'(W) : 64'd0);
        check({tag, "_sram_addr"}, 64'(sa), exp_hit ? 64'(prev_addr) : 64'(wd));
        check({tag, "_rd_data"}, 64'(rd), 64'(last_rd));
    endtask

    initial begin
        RST_N    = 1'b0;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        ADDR     = 32'h0;
        WR_DATA  = 32'h0;
        #12;
        check("rst_we_n", 64'(SRAM_WE_N), 64'd1);
        check("rst_sram_addr", 64'(SRAM_ADDR), 64'd0);
        check("rst_rd_data", 64'(RD_DATA), 64'd0);
        check("rst_ready", 64'(READY), 64'd1);
        @(negedge CLK);
        RST_N = 1'b1;

        // write then read, even word
        access(1, 0, 32'd1024, 32'hDEAD_BEEF, "t2_w");
        access(0, 1, 32'd1024, 32'h0, "t2_r");
        // odd word comes from the high half of the line
        access(1, 0, 32'd1028, 32'd7, "t3_w");
        access(0, 1, 32'd1028, 32'h0, "t3_r");
        access(0, 1, 32'd1024, 32'h0, "t3_r_even");
        // both enables: write wins
        access(1, 1, 32'd1032, 32'd5, "t4_wr");
        check("t4_mem2", 64'(sram_mem[2]), 64'd5);
        access(0, 1, 32'd1032, 32'h0, "t4_r");
        // cache sequence (plain reads when the line buffer is absent)
        access(0, 1, 32'd1028, 32'h0, "t5_r_1028");
        access(1, 0, 32'd1028, 32'd9, "t5_w");
        access(0, 1, 32'd1028, 32'h0, "t5_r_again");
        // address wraps modulo 2^17 words
        access(1, 0, BASE + 32'd524288, 32'h1234_5678, "t6_wrap_w");
        access(0, 1, 32'd1024, 32'h0, "t6_r");

        // asynchronous reset in the middle of a write access
        @(negedge CLK);
        MEM_W_EN = 1'b1;
        ADDR     = 32'd1024;
        WR_DATA  = 32'h1234_5678;
        @(negedge CLK);
        @(negedge CLK);
        #2;
        mdl_drive = 1'b0;
        RST_N     = 1'b0;
        #1;
        check("t1_we_n", 64'(SRAM_WE_N), 64'd1);
        // bus released: DUT no longer drives the write word onto DQ
        check("t1_dq_released", 64'(SRAM_DQ[31:0] !== WR_DATA), 64'd1);
        MEM_W_EN = 1'b0;
        #1;
        check("t1_ready", 64'(READY), 64'd1);
        check("t1_rd_data", 64'(RD_DATA), 64'd0);
        check("t1_sram_addr", 64'(SRAM_ADDR), 64'd0);
        last_rd = 32'h0;
        cm_vld  = 1'b0;
        @(negedge CLK);
        mdl_drive = 1'b1;
        RST_N     = 1'b1;

        // randomized traffic over a few lines, with occasional wrapped aliases
        for (int i = 0; i < 40; i++) begin
            int          op;
            logic [31:0] a;
            op = int'($urandom_range(0, 2));
            a  = BASE + 32'(4 * $urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = a + 32'd524288;
            case (op)
                0:       access(0, 1, a, 32'h0, "rnd_r");
                1:       access(1, 0, a, $urandom, "rnd_w");
                default: access(1, 1, a, $urandom, "rnd_rw");
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
